pipe_fwd_regs: RTL
==================

// Module: pipe_fwd_regs
// PURPOSE
//   Consumer end of the hazard unit's stall/forward interface: owns the F/D, D/E, E/M, M/W
//   pipeline registers of the 5-stage MIPS core and applies the stall and forward-select codes.
//   Freezes F/D and the PC on stall, injects a bubble into D/E, muxes forwarded operands into
//   D (branch/jr compare), E (ALU inputs) and M (store data). Sits between PC/IM, GRF, ALU, DM.
// PARAMETERS
//   RESET_PC  32'h0000_3000  PC value loaded into every stage PC register on reset
// PORTS
//   clk       in   1   rising-edge clock
//   reset     in   1   asynchronous, active-low reset
//   stall     in   1   from hazard unit: hold PC/F-D, bubble D-E
//   FRSD      in   3   forward select, D-stage rs operand
//   FRTD      in   3   forward select, D-stage rt operand
//   FRSE      in   3   forward select, E-stage rs operand
//   FRTE      in   3   forward select, E-stage rt operand
//   FRTM      in   1   forward select, M-stage store data (1 = W write data)
//   F_IR      in   32  instruction fetched this cycle
//   F_PC      in   32  PC of F_IR
//   RF_RD1    in   32  GRF read of D_IR[25:21]
//   RF_RD2    in   32  GRF read of D_IR[20:16]
//   E_ALU     in   32  ALU result of instruction in E
//   M_DMRD    in   32  DM read data of instruction in M
//   pc_en     out  1   PC write enable, = ~stall
//   D_IR/D_PC out  32  F-D register contents
//   D_RS/D_RT out  32  forwarded D-stage operands (to comparator / jr target / E latch)
//   E_IR/E_PC out  32  D-E register contents
//   E_RS/E_RT out  32  forwarded E-stage operands (to ALU)
//   M_IR/M_PC/M_ALU out 32  E-M register contents
//   M_WD      out  32  forwarded store data (to DM)
//   W_IR/W_PC/W_ALU/W_DM out 32  M-W register contents
// BEHAVIOUR
//   - Reset (reset==0, async): all IR regs 0 (nop), all PC regs RESET_PC, all data regs 0.
//     Reset dominates stall on the same edge; release is synchronous to next clk rise.
//   - Each edge, stall==0: F-D <= {F_IR,F_PC}; D-E <= {D_IR,D_PC,D_RS,D_RT};
//     E-M <= {E_IR,E_PC,E_ALU,E_RT}; M-W <= {M_IR,M_PC,M_ALU,M_DMRD}.
//   - stall==1: F-D holds; D-E loads bubble (IR=0, PC=RESET_PC, RS=RT=0); E-M, M-W advance
//     normally. Consecutive stall cycles keep holding F-D and re-bubbling D-E.
//   - pc_en is combinational ~stall; 0 while in reset is not required (PC owns its reset).
//   - Forward code map (FRSD/FRTD/FRSE/FRTE), combinational:
//     000 own value (RF_RD1/RF_RD2 in D; latched RS/RT in E)   001 W_DM
//     010 W_ALU   011 W_PC+8   100 M_PC+8   101 M_ALU   110/111 treated as 000.
//   - M_WD = FRTM ? W write data : latched M rt; W write data = W_DM if W_IR is lw,
//     W_PC+8 if jal/blezals (opcode 000011/011000), else W_ALU.
//   - PC+8 computed as 32-bit add, wrap-around modulo 2^32 (no carry out).
//   - D-E latches the forwarded D_RS/D_RT, not raw RF data, so W-stage writes in the
//     same cycle are never lost.
//   - No state machine beyond the stage registers; latency F->W = 4 cycles absent stalls.
// TESTING
//   1 reset low mid-run with stall=1 -> next cycle all IR=0, all PC=32'h3000, pc_en follows ~stall.
//   2 F_IR=addu $3,$1,$2 then addu $4,$3,$3, hazard FRSE=FRTE=101, E_ALU=32'h5 -> E_RS=E_RT=5.
//   3 stall=1 for 2 cycles with F_IR=X -> D_IR holds X, E_IR=0 both cycles, M/W advance, pc_en=0.
//   4 jal at PC 32'h3008 in M, beq in D with FRSD=100 -> D_RS=32'h3010.
//   5 lw in W with W_DM=32'hDEAD_BEEF, sw in M with FRTM=1 -> M_WD=32'hDEAD_BEEF.
//   6 FRSD=3'b110 with RF_RD1=32'h1234 -> D_RS=32'h1234; W_PC=32'hFFFF_FFFC, code 011 -> 32'h4.

Source files
------------

// File: rtl/pipe_fwd_regs.sv
`default_nettype none
// ============================================================================
// Module      : pipe_fwd_regs
// Description : F/D, D/E, E/M and M/W pipeline registers of the 5-stage MIPS
//               core. Applies the hazard unit's stall and forward-select codes:
//               freezes F/D (and the PC via pc_en) on stall, injects a bubble
//               into D/E, and muxes forwarded operands into D (branch/jr
//               compare), E (ALU inputs) and M (store data).
// Ports       : clk, reset (async, active-low)
//               stall, FRSD/FRTD/FRSE/FRTE (3b codes), FRTM (1b)
//               F_IR/F_PC, RF_RD1/RF_RD2, E_ALU, M_DMRD    (stage inputs)
//               pc_en, D_*, E_*, M_*, W_*                  (stage outputs)
//               Forward code: 000 own, 001 W_DM, 010 W_ALU, 011 W_PC+8,
//                             100 M_PC+8, 101 M_ALU, 110/111 own.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_fwd_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  FRSD,
    input  logic [2:0]  FRTD,
    input  logic [2:0]  FRSE,
    input  logic [2:0]  FRTE,
    input  logic        FRTM,
    input  logic [31:0] F_IR,
    input  logic [31:0] F_PC,
    input  logic [31:0] RF_RD1,
    input  logic [31:0] RF_RD2,
    input  logic [31:0] E_ALU,
    input  logic [31:0] M_DMRD,
    output logic        pc_en,
    output logic [31:0] D_IR,
    output logic [31:0] D_PC,
    output logic [31:0] D_RS,
    output logic [31:0] D_RT,
    output logic [31:0] E_IR,
    output logic [31:0] E_PC,
    output logic [31:0] E_RS,
    output logic [31:0] E_RT,
    output logic [31:0] M_IR,
    output logic [31:0] M_PC,
    output logic [31:0] M_ALU,
    output logic [31:0] M_WD,
    output logic [31:0] W_IR,
    output logic [31:0] W_PC,
    output logic [31:0] W_ALU,
    output logic [31:0] W_DM
);

    localparam logic [5:0]  c_OP_LW      = 6'b100011;
    localparam logic [5:0]  c_OP_JAL     = 6'b000011;
    localparam logic [5:0]  c_OP_BLEZALS = 6'b011000;
    localparam logic [31:0] c_LINK_OFS   = 32'd8;

    // Stage registers
    logic [31:0] r_d_ir, r_d_pc;
    logic [31:0] r_e_ir, r_e_pc, r_e_rs, r_e_rt;
    logic [31:0] r_m_ir, r_m_pc, r_m_alu, r_m_rt;
    logic [31:0] r_w_ir, r_w_pc, r_w_alu, r_w_dm;

    // Forwarding sources
    logic [31:0] w_w_link;
    logic [31:0] w_m_link;
    logic [31:0] w_w_wdata;
    logic [31:0] w_d_rs, w_d_rt, w_e_rs, w_e_rt;

    // Link addresses wrap modulo 2^32; the carry is deliberately dropped.
    assign w_w_link = r_w_pc + c_LINK_OFS;
    assign w_m_link = r_m_pc + c_LINK_OFS;

    // Value the W stage writes back to the GRF.
    always_comb begin
        w_w_wdata = r_w_alu;
        if (r_w_ir[31:26] == c_OP_LW) begin
            w_w_wdata = r_w_dm;
        end else if ((r_w_ir[31:26] == c_OP_JAL) || (r_w_ir[31:26] == c_OP_BLEZALS)) begin
            w_w_wdata = w_w_link;
        end
    end

    function automatic logic [31:0] fwd_mux(
        input logic [2:0]  sel,
        input logic [31:0] own,
        input logic [31:0] w_dm,
        input logic [31:0] w_alu,
        input logic [31:0] w_link,
        input logic [31:0] m_link,
        input logic [31:0] m_alu
    );
        logic [31:0] v;
        case (sel)
            3'b001:  v = w_dm;
            3'b010:  v = w_alu;
            3'b011:  v = w_link;
            3'b100:  v = m_link;
            3'b101:  v = m_alu;
            default: v = own;   // 000 and the unused 110/111
        endcase
        return v;
    endfunction

    always_comb begin
        w_d_rs = fwd_mux(FRSD, RF_RD1, r_w_dm, r_w_alu, w_w_link, w_m_link, r_m_alu);
        w_d_rt = fwd_mux(FRTD, RF_RD2, r_w_dm, r_w_alu, w_w_link, w_m_link, r_m_alu);
        w_e_rs = fwd_mux(FRSE, r_e_rs, r_w_dm, r_w_alu, w_w_link, w_m_link, r_m_alu);
        w_e_rt = fwd_mux(FRTE, r_e_rt, r_w_dm, r_w_alu, w_w_link, w_m_link, r_m_alu);
    end

    // Pipeline registers. D/E captures the forwarded D operands so that a
    // GRF write happening in W during the same cycle is not lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d_ir  <= '0;
            r_d_pc  <= RESET_PC;
            r_e_ir  <= '0;
            r_e_pc  <= RESET_PC;
            r_e_rs  <= '0;
            r_e_rt  <= '0;
            r_m_ir  <= '0;
            r_m_pc  <= RESET_PC;
            r_m_alu <= '0;
            r_m_rt  <= '0;
            r_w_ir  <= '0;
            r_w_pc  <= RESET_PC;
            r_w_alu <= '0;
            r_w_dm  <= '0;
        end else begin
            if (stall) begin
                // F/D holds; D/E gets a nop bubble
                r_e_ir <= '0;
                r_e_pc <= RESET_PC;
                r_e_rs <= '0;
                r_e_rt <= '0;
            end else begin
                r_d_ir <= F_IR;
                r_d_pc <= F_PC;
                r_e_ir <= r_d_ir;
                r_e_pc <= r_d_pc;
                r_e_rs <= w_d_rs;
                r_e_rt <= w_d_rt;
            end
            r_m_ir  <= r_e_ir;
            r_m_pc  <= r_e_pc;
            r_m_alu <= E_ALU;
            r_m_rt  <= w_e_rt;
            r_w_ir  <= r_m_ir;
            r_w_pc  <= r_m_pc;
            r_w_alu <= r_m_alu;
            r_w_dm  <= M_DMRD;
        end
    end

    assign pc_en = ~stall;
    assign D_IR  = r_d_ir;
    assign D_PC  = r_d_pc;
    assign D_RS  = w_d_rs;
    assign D_RT  = w_d_rt;
    assign E_IR  = r_e_ir;
    assign E_PC  = r_e_pc;
    assign E_RS  = w_e_rs;
    assign E_RT  = w_e_rt;
    assign M_IR  = r_m_ir;
    assign M_PC  = r_m_pc;
    assign M_ALU = r_m_alu;
    assign M_WD  = FRTM ? w_w_wdata : r_m_rt;
    assign W_IR  = r_w_ir;
    assign W_PC  = r_w_pc;
    assign W_ALU = r_w_alu;
    assign W_DM  = r_w_dm;

endmodule
`default_nettype wire
